// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver. 2-flop synchronizer, mid-cell
// 2-of-3 majority vote, optional parity check, stop-bit check, one-cycle
// result strobes.
module uart_rx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = 1;
    localparam logic [BW-1:0]             B_ONE    = 1;
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state, state_nxt;
    logic                      rx_m, rx_s;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BW-1:0]             bit_cnt;
    logic                      s_lo, s_mid;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_en_q, par_typ_q, bad_frame;
    logic                      dv_nxt, perr_nxt, serr_nxt;

    logic [PRESCALE_WIDTH-1:0] half, pt_lo, pt_hi, last_cnt;
    logic                      at_dec, at_last, maj, exp_par;

    assign half     = PRESCALE >> 1;
    assign pt_lo    = half - P_ONE;
    assign pt_hi    = half + P_ONE;
    assign last_cnt = PRESCALE - P_ONE;
    assign at_dec   = (edge_cnt == pt_hi);
    assign at_last  = (edge_cnt == last_cnt);
    // Third vote is the live sample taken in the decision cycle itself.
    assign maj      = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign exp_par  = par_typ_q ? ~^shift_reg : ^shift_reg;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX_IN;
            rx_s <= rx_m;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and result-strobe decode.
    always_comb begin
        state_nxt = state;
        dv_nxt    = 1'b0;
        perr_nxt  = 1'b0;
        serr_nxt  = 1'b0;
        case (state)
            IDLE:   if (!rx_s) state_nxt = START;
            START: begin
                if (at_dec && maj) state_nxt = IDLE;
                else if (at_last)  state_nxt = DATA;
            end
            DATA:   if (at_last && bit_cnt == LAST_BIT)
                        state_nxt = par_en_q ? PARITY : STOP;
            PARITY: begin
                if (at_dec && (maj != exp_par)) perr_nxt = 1'b1;
                if (at_last) state_nxt = STOP;
            end
            STOP: begin
                // Leave mid stop cell so the next start edge is never missed.
                if (at_dec) begin
                    state_nxt = IDLE;
                    if (!maj)           serr_nxt = 1'b1;
                    else if (!bad_frame) dv_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, sampling, shift register, frame settings and outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            s_lo       <= 1'b1;
            s_mid      <= 1'b1;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bad_frame  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= dv_nxt;
            PAR_ERR    <= perr_nxt;
            STP_ERR    <= serr_nxt;
            if (dv_nxt) P_DATA <= shift_reg;

            if (state == IDLE || state_nxt == IDLE || at_last) edge_cnt <= '0;
            else                                               edge_cnt <= edge_cnt + P_ONE;

            if (edge_cnt == pt_lo) s_lo  <= rx_s;
            if (edge_cnt == half)  s_mid <= rx_s;

            if (state != DATA)
                bit_cnt <= '0;
            else if (at_last)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + B_ONE;

            if (state == DATA && at_dec)
                shift_reg <= {maj, shift_reg[DATA_WIDTH-1:1]};

            if (state == IDLE && state_nxt == START) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                bad_frame <= 1'b0;
            end else if (perr_nxt) begin
                bad_frame <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed scenarios for uart_rx_core with hand-computed
// strobe cycles and data values.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd16;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int dv_n = 0, pe_n = 0, se_n = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] dv_dat = '0;

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(clk), .RST(rst), .RX_IN(rx_in), .PRESCALE(prescale),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
        .DATA_VALID(data_valid), .PAR_ERR(par_err), .STP_ERR(stp_err)
    );

    // 10 ns clock; cyc counts rising edges.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Record strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin dv_n++; dv_cyc = cyc; dv_dat = p_data; end
        if (par_err)    begin pe_n++; pe_cyc = cyc; end
        if (stp_err)    begin se_n++; se_cyc = cyc; end
    end

    // Drive one frame cycle by cycle; d returns the edge after which the start
    // bit went onto the line. ncells=0 sends the whole frame.
    task automatic send_frame(input logic [7:0] data, input logic pe, input logic pb,
                              input logic sb, input int p, input int glitch_i,
                              input int ncells, output int d);
        logic [10:0] fr;
        int n;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = data;
        if (pe) begin fr[9] = pb; fr[10] = sb; n = 11; end
        else    begin fr[9] = sb; n = 10; end
        if (ncells != 0) n = ncells;
        prescale = 6'(p);
        par_en = pe;
        d = 0;
        for (int i = 0; i < n * p; i++) begin
            @(posedge clk); #1;
            if (i == 0) d = cyc;
            rx_in = fr[i / p] ^ (i == glitch_i);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (p_data !== 8'h00) begin n_fail++; $display("FAIL reset_p_data got %h want 00", p_data); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", data_valid); end
        n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err got %b want 0", par_err); end
        n_checks++; if (stp_err !== 1'b0) begin n_fail++; $display("FAIL reset_stp_err got %b want 0", stp_err); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_no_parity;
        int d, dv0, pe0, se0;
        dv0 = dv_n; pe0 = pe_n; se0 = se_n;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, -1, 0, d);
        idle(20);
        n_checks++; if (dv_n - dv0 != 1) begin n_fail++; $display("FAIL np_dv_count got %0d want 1", dv_n - dv0); end
        n_checks++; if (dv_cyc != d + 3 + 154) begin n_fail++; $display("FAIL np_dv_cycle got %0d want %0d", dv_cyc - d - 3, 154); end
        n_checks++; if (dv_dat !== 8'hA5) begin n_fail++; $display("FAIL np_data got %h want a5", dv_dat); end
        n_checks++; if (pe_n != pe0 || se_n != se0) begin n_fail++; $display("FAIL np_errors got %0d/%0d want 0/0", pe_n - pe0, se_n - se0); end
        n_checks++; if (p_data !== 8'hA5) begin n_fail++; $display("FAIL np_p_data_hold got %h want a5", p_data); end
    endtask

    task automatic test_even_parity;
        int d, dv0, pe0;
        dv0 = dv_n; pe0 = pe_n;
        par_typ = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1, 0, d);
        idle(20);
        n_checks++; if (dv_n - dv0 != 1) begin n_fail++; $display("FAIL ep_dv_count got %0d want 1", dv_n - dv0); end
        n_checks++; if (dv_cyc != d + 3 + 170) begin n_fail++; $display("FAIL ep_dv_cycle got %0d want %0d", dv_cyc - d - 3, 170); end
        n_checks++; if (dv_dat !== 8'h3C) begin n_fail++; $display("FAIL ep_data got %h want 3c", dv_dat); end
        n_checks++; if (pe_n != pe0) begin n_fail++; $display("FAIL ep_par_err got %0d want 0", pe_n - pe0); end
    endtask

    task automatic test_parity_error;
        int d, dv0, pe0, se0;
        dv0 = dv_n; pe0 = pe_n; se0 = se_n;
        par_typ = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 16, -1, 0, d);
        idle(20);
        n_checks++; if (pe_n - pe0 != 1) begin n_fail++; $display("FAIL pe_count got %0d want 1", pe_n - pe0); end
        n_checks++; if (pe_cyc != d + 3 + 154) begin n_fail++; $display("FAIL pe_cycle got %0d want %0d", pe_cyc - d - 3, 154); end
        n_checks++; if (dv_n != dv0 || se_n != se0) begin n_fail++; $display("FAIL pe_other got dv %0d stp %0d want 0 0", dv_n - dv0, se_n - se0); end
        n_checks++; if (p_data !== 8'h3C) begin n_fail++; $display("FAIL pe_p_data_hold got %h want 3c", p_data); end
        par_typ = 1'b0;
    endtask

    task automatic test_stop_error;
        int d, dv0, se0;
        dv0 = dv_n; se0 = se_n;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8, -1, 0, d);
        idle(40);
        n_checks++; if (se_n - se0 != 1) begin n_fail++; $display("FAIL se_count got %0d want 1", se_n - se0); end
        n_checks++; if (se_cyc != d + 3 + 78) begin n_fail++; $display("FAIL se_cycle got %0d want %0d", se_cyc - d - 3, 78); end
        n_checks++; if (dv_n != dv0) begin n_fail++; $display("FAIL se_no_dv got %0d want 0", dv_n - dv0); end
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 8, -1, 0, d);
        idle(20);
        n_checks++; if (dv_n - dv0 != 1) begin n_fail++; $display("FAIL se_recover_count got %0d want 1", dv_n - dv0); end
        n_checks++; if (dv_dat !== 8'h33) begin n_fail++; $display("FAIL se_recover_data got %h want 33", dv_dat); end
    endtask

    task automatic test_start_glitch;
        int d, dv0, pe0, se0;
        dv0 = dv_n; pe0 = pe_n; se0 = se_n;
        prescale = 6'd16;
        par_en = 1'b0;
        @(posedge clk); #1;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(48);
        n_checks++; if (dv_n != dv0 || pe_n != pe0 || se_n != se0) begin n_fail++; $display("FAIL glitch_pulses got %0d/%0d/%0d want 0/0/0", dv_n - dv0, pe_n - pe0, se_n - se0); end
        // Line index 73 lands on the middle vote of data bit 3.
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 16, 73, 0, d);
        idle(20);
        n_checks++; if (dv_n - dv0 != 1) begin n_fail++; $display("FAIL vote_count got %0d want 1", dv_n - dv0); end
        n_checks++; if (dv_dat !== 8'hF0) begin n_fail++; $display("FAIL vote_data got %h want f0", dv_dat); end
    endtask

    task automatic test_back_to_back;
        int d1, d2, dv0;
        dv0 = dv_n;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 32, -1, 0, d1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 32, -1, 5, d2);
        n_checks++; if (dv_n - dv0 != 1) begin n_fail++; $display("FAIL b2b_count got %0d want 1", dv_n - dv0); end
        n_checks++; if (dv_cyc != d1 + 3 + 9 * 32 + 18) begin n_fail++; $display("FAIL b2b_cycle got %0d want %0d", dv_cyc - d1 - 3, 306); end
        n_checks++; if (dv_dat !== 8'h81) begin n_fail++; $display("FAIL b2b_data got %h want 81", dv_dat); end
        n_checks++; if (d2 != d1 + 320) begin n_fail++; $display("FAIL b2b_gap got %0d want 320", d2 - d1); end
        rst = 1'b1;
        #1;
        n_checks++; if (p_data !== 8'h00 || data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_frame got %h/%b want 00/0", p_data, data_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(12 * 32);
        n_checks++; if (dv_n - dv0 != 1) begin n_fail++; $display("FAIL rst_no_strobe got %0d want 1", dv_n - dv0); end
        n_checks++; if (p_data !== 8'h00) begin n_fail++; $display("FAIL rst_p_data got %h want 00", p_data); end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_even_parity();
        test_parity_error();
        test_stop_error();
        test_start_glitch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
